// File: rtl/row_render.sv
// Purpose : per-column wall/floor classifier for one visible VGA line; reads the
//           trace buffer at h=c and emits the registered pixel class at h=c+2.
// Ports   : clk/reset; h,v VGA counters; tb_* trace buffer read port (read-only,
//           tb_busy blocks reads); px_* pixel classification; tb_conflict sticky.
module row_render #(
  parameter int          H_VIS   = 640,
  parameter int          V_VIS   = 480,
  parameter int          HORIZON = 240,
  parameter logic [24:0] WALL_K  = 25'd122880
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [9:0]  h,
  input  logic [9:0]  v,
  input  logic        tb_busy,
  output logic        tb_cs,
  output logic        tb_oe,
  output logic        tb_we,
  output logic [9:0]  tb_column,
  input  logic [15:0] tb_vdist,
  input  logic        tb_side,
  input  logic [5:0]  tb_tex,
  output logic        px_valid,
  output logic        px_wall,
  output logic        px_floor,
  output logic        px_side,
  output logic [5:0]  px_tex,
  output logic        tb_conflict
);

  localparam logic [9:0] H_END  = 10'(H_VIS);
  localparam logic [9:0] H_LAST = 10'(H_VIS - 1);
  localparam logic [9:0] V_END  = 10'(V_VIS);
  localparam logic [9:0] HOR    = 10'(HORIZON);

  typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN} state_t;

  state_t state_q, state_d;
  logic   drain_cnt_q, drain_cnt_d;

  // The first column must be read on the very clk the line starts, so the
  // start condition counts as an ACTIVE clk while the register is still IDLE.
  logic start, line_clk, slot, rd;
  assign start    = (state_q == IDLE) && (h == 10'd0) && (v < V_END);
  assign line_clk = (state_q == ACTIVE) || start;
  assign slot     = !reset && line_clk && (h < H_END);
  assign rd       = slot && !tb_busy;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      drain_cnt_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d     = state_q;
    drain_cnt_d = 1'b0;
    case (state_q)
      IDLE:    if (start) state_d = (h == H_LAST) ? DRAIN : ACTIVE;
      ACTIVE:  if (h == H_LAST) state_d = DRAIN;
      DRAIN: begin
        drain_cnt_d = 1'b1;
        if (drain_cnt_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic: trace buffer read port
  always_comb begin
    tb_cs     = rd;
    tb_oe     = rd;
    tb_we     = 1'b0;
    tb_column = rd ? h : 10'd0;
  end

  // Stage 1: captured on the issue edge, so it lines up with the buffer's
  // registered tb_vdist/tb_side/tb_tex in the following clk. rowdist and the
  // floor side are taken from v at issue so a mid-line v change cannot leak in.
  logic [9:0] vdiff;
  logic       s1_slot_q, s1_rd_q, s1_below_q;
  logic [8:0] s1_rowdist_q, s1_rowdist_d;

  assign vdiff        = (v >= HOR) ? (v - HOR) : (HOR - v);
  assign s1_rowdist_d = vdiff[8:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_slot_q    <= 1'b0;
      s1_rd_q      <= 1'b0;
      s1_below_q   <= 1'b0;
      s1_rowdist_q <= 9'd0;
    end else begin
      s1_slot_q    <= slot;
      s1_rd_q      <= rd;
      s1_below_q   <= (v >= HOR);
      s1_rowdist_q <= s1_rowdist_d;
    end
  end

  // Stage 2: full-width product, classification, registered outputs.
  // A suppressed read (tb_busy) keeps its slot but classifies as nothing.
  logic [24:0] prod;
  logic        wall_d, floor_d;

  assign prod    = {16'd0, s1_rowdist_q} * {9'd0, tb_vdist};
  assign wall_d  = s1_rd_q &&
                   ((tb_vdist == 16'd0) || ((tb_vdist != 16'hFFFF) && (prod < WALL_K)));
  assign floor_d = s1_rd_q && !wall_d && s1_below_q;

  logic       px_valid_q, px_wall_q, px_floor_q, px_side_q, conflict_q;
  logic [5:0] px_tex_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      px_valid_q <= 1'b0;
      px_wall_q  <= 1'b0;
      px_floor_q <= 1'b0;
      px_side_q  <= 1'b0;
      px_tex_q   <= 6'd0;
      conflict_q <= 1'b0;
    end else begin
      px_valid_q <= s1_slot_q;
      px_wall_q  <= wall_d;
      px_floor_q <= floor_d;
      px_side_q  <= wall_d && tb_side;
      px_tex_q   <= wall_d ? tb_tex : 6'd0;
      if (line_clk && tb_busy) conflict_q <= 1'b1;
    end
  end

  assign px_valid    = px_valid_q;
  assign px_wall     = px_wall_q;
  assign px_floor    = px_floor_q;
  assign px_side     = px_side_q;
  assign px_tex      = px_tex_q;
  assign tb_conflict = conflict_q;

endmodule

// File: tb/tb_row_render.sv
// Bench for row_render: drives 800-clk VGA lines against a 1-clk-latency
// trace buffer model, checks every clk against a behavioural model, and pins
// the model with hand-computed literal expectations.
module tb_row_render;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  h, v;
  logic        tb_busy;
  logic        tb_cs, tb_oe, tb_we;
  logic [9:0]  tb_column;
  logic [15:0] tb_vdist = 16'd0;
  logic        tb_side = 1'b0;
  logic [5:0]  tb_tex = 6'd0;
  logic        px_valid, px_wall, px_floor, px_side, tb_conflict;
  logic [5:0]  px_tex;

  always #5 clk = ~clk;

  row_render dut (
    .clk(clk), .reset(reset), .h(h), .v(v), .tb_busy(tb_busy),
    .tb_cs(tb_cs), .tb_oe(tb_oe), .tb_we(tb_we), .tb_column(tb_column),
    .tb_vdist(tb_vdist), .tb_side(tb_side), .tb_tex(tb_tex),
    .px_valid(px_valid), .px_wall(px_wall), .px_floor(px_floor),
    .px_side(px_side), .px_tex(px_tex), .tb_conflict(tb_conflict)
  );

  // Trace buffer contents and 1-clk read model; idle cycles present junk that
  // would look like a wall if the DUT ignored its read-valid.
  logic [15:0] m_vd [640];
  logic        m_sd [640];
  logic [5:0]  m_tx [640];

  always @(posedge clk) begin
    if (tb_cs && tb_oe && tb_column < 10'd640) begin
      tb_vdist <= m_vd[tb_column];
      tb_side  <= m_sd[tb_column];
      tb_tex   <= m_tx[tb_column];
    end else begin
      tb_vdist <= 16'd0;
      tb_side  <= 1'b1;
      tb_tex   <= 6'h3F;
    end
  end

  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;

  // Behavioural model: a record per clk of what was asked of the block.
  typedef struct {
    bit          rst;
    bit          busy;
    bit          slot;
    int          vv;
    int          col;
    logic [15:0] vd;
    logic        sd;
    logic [5:0]  tx;
  } rec_t;

  rec_t hist[$];
  bit   line_on  = 1'b0;
  bit   conf_exp = 1'b0;

  always @(negedge clk) begin
    rec_t r, p, q;
    bit ev, ew, ef, es, ecs;
    logic [5:0] et;
    logic [9:0] ecol;
    int rdist, prod;
    logic [23:0] act, exp_v;

    r.rst  = reset;
    r.busy = tb_busy;
    r.vv   = int'(v);
    r.col  = int'(h);
    if (!reset && h == 10'd0) line_on = (v < 10'd480);
    r.slot = !reset && line_on && (h < 10'd640);
    if (reset) line_on = 1'b0;
    r.vd = (h < 10'd640) ? m_vd[h] : 16'd0;
    r.sd = (h < 10'd640) ? m_sd[h] : 1'b0;
    r.tx = (h < 10'd640) ? m_tx[h] : 6'd0;
    hist.push_back(r);
    if (hist.size() > 3) void'(hist.pop_front());

    if (chk_on && hist.size() == 3) begin
      p = hist[0];   // column issued two clks ago
      q = hist[1];
      ev = 0; ew = 0; ef = 0; es = 0; et = 6'd0;
      if (p.slot && !q.rst) begin
        ev = 1;
        if (!p.busy) begin
          rdist = (p.vv >= 240) ? p.vv - 240 : 240 - p.vv;
          prod  = rdist * int'(p.vd);
          ew = (p.vd == 16'd0) || (p.vd != 16'hFFFF && prod < 122880);
          ef = !ew && p.vv >= 240;
          es = ew && p.sd;
          et = ew ? p.tx : 6'd0;
        end
      end
      ecs   = r.slot && !r.busy;
      ecol  = ecs ? 10'(r.col) : 10'd0;
      exp_v = {ev, ew, ef, es, et, ecs, ecs, 1'b0, ecol, conf_exp};
      act   = {px_valid, px_wall, px_floor, px_side, px_tex,
               tb_cs, tb_oe, tb_we, tb_column, tb_conflict};
      checks++;
      if (act !== exp_v) begin
        errors++;
        $display("FAIL cycle_out h=%0d v=%0d got %h want %h", r.col, r.vv, act, exp_v);
      end
    end

    if (reset) conf_exp = 1'b0;
    else if (r.slot && r.busy) conf_exp = 1'b1;
  end

  task automatic lit(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, got, want);
    end
  endtask

  task automatic cyc(input int hh, input int vv, input bit bb, input bit rr);
    @(posedge clk);
    #1;
    h = 10'(hh); v = 10'(vv); tb_busy = bb; reset = rr;
    @(negedge clk);
    #1;
  endtask

  logic       cap_valid [800];
  logic       cap_wall  [800];
  logic       cap_floor [800];
  logic       cap_side  [800];
  logic [5:0] cap_tex   [800];
  logic       cap_cs    [800];
  logic       cap_conf  [800];

  // One full line; optional busy window, reset column and mid-line v switch.
  task automatic line(input int vv, input int b_lo, input int b_hi,
                      input int rst_h, input int v2_h, input int v2);
    for (int hh = 0; hh < 800; hh++) begin
      cyc(hh, (hh >= v2_h) ? v2 : vv, (hh >= b_lo && hh <= b_hi), (hh == rst_h));
      cap_valid[hh] = px_valid;
      cap_wall[hh]  = px_wall;
      cap_floor[hh] = px_floor;
      cap_side[hh]  = px_side;
      cap_tex[hh]   = px_tex;
      cap_cs[hh]    = tb_cs;
      cap_conf[hh]  = tb_conflict;
    end
  endtask

  task automatic plain(input int vv);
    line(vv, 1000, 1000, 1000, 1000, 0);
  endtask

  initial begin
    int n_cs, n_valid;
    h = 10'd700; v = 10'd524; tb_busy = 1'b0; reset = 1'b1;
    for (int c = 0; c < 640; c++) begin
      m_vd[c] = 16'h0200;
      m_sd[c] = c[0];
      m_tx[c] = 6'(c % 64);
    end

    cyc(700, 524, 0, 1);
    cyc(701, 524, 0, 1);
    chk_on = 1'b1;
    cyc(702, 524, 0, 1);
    lit("rst_px_valid", {31'd0, px_valid}, 0);
    lit("rst_tb_cs", {31'd0, tb_cs}, 0);
    lit("rst_conflict", {31'd0, tb_conflict}, 0);
    for (int hh = 703; hh < 800; hh++) cyc(hh, 524, 0, 0);

    // rowdist 240 * 1.0 == WALL_K: not a wall, above horizon so not floor
    plain(0);
    lit("v0_valid_h1", {31'd0, cap_valid[1]}, 0);
    lit("v0_valid_h2", {31'd0, cap_valid[2]}, 1);
    lit("v0_wall_c0", {31'd0, cap_wall[2]}, 0);
    lit("v0_floor_c0", {31'd0, cap_floor[2]}, 0);
    lit("v0_valid_h641", {31'd0, cap_valid[641]}, 1);
    lit("v0_valid_h642", {31'd0, cap_valid[642]}, 0);

    // rowdist 239 * 512 = 122368 < WALL_K: wall everywhere
    plain(1);
    lit("v1_wall_c0", {31'd0, cap_wall[2]}, 1);
    lit("v1_tex_c10", {26'd0, cap_tex[12]}, 10);
    lit("v1_side_c11", {31'd0, cap_side[13]}, 1);
    lit("v1_wall_c639", {31'd0, cap_wall[641]}, 1);
    lit("v1_valid_h642", {31'd0, cap_valid[642]}, 0);

    m_vd[5] = 16'hFFFF;
    m_vd[6] = 16'h0000;
    plain(479);
    lit("v479_wall_c5", {31'd0, cap_wall[7]}, 0);
    lit("v479_floor_c5", {31'd0, cap_floor[7]}, 1);
    lit("v479_wall_c6", {31'd0, cap_wall[8]}, 1);
    lit("v479_tex_c6", {26'd0, cap_tex[8]}, 6);
    lit("v479_wall_c7", {31'd0, cap_wall[9]}, 1);

    plain(240);
    lit("v240_floor_c5", {31'd0, cap_floor[7]}, 1);

    line(10, 100, 101, 1000, 1000, 0);
    lit("busy_cs_h100", {31'd0, cap_cs[100]}, 0);
    lit("busy_cs_h101", {31'd0, cap_cs[101]}, 0);
    lit("busy_cs_h102", {31'd0, cap_cs[102]}, 1);
    lit("busy_valid_c100", {31'd0, cap_valid[102]}, 1);
    lit("busy_wall_c100", {31'd0, cap_wall[102]}, 0);
    lit("busy_wall_c101", {31'd0, cap_wall[103]}, 0);
    lit("busy_wall_c102", {31'd0, cap_wall[104]}, 1);
    lit("conf_before", {31'd0, cap_conf[100]}, 0);
    lit("conf_after", {31'd0, cap_conf[101]}, 1);
    lit("conf_sticky", {31'd0, cap_conf[700]}, 1);

    line(50, 1000, 1000, 300, 1000, 0);
    lit("rst_mid_valid_h300", {31'd0, cap_valid[300]}, 1);
    lit("rst_mid_valid_h301", {31'd0, cap_valid[301]}, 0);
    lit("rst_mid_valid_h500", {31'd0, cap_valid[500]}, 0);
    lit("rst_mid_conf_h299", {31'd0, cap_conf[299]}, 1);
    lit("rst_mid_conf_h301", {31'd0, cap_conf[301]}, 0);
    plain(51);
    lit("after_rst_valid_h2", {31'd0, cap_valid[2]}, 1);
    lit("after_rst_wall_c0", {31'd0, cap_wall[2]}, 1);

    // varied distances, v jumps 100 -> 400 at h=320
    for (int c = 0; c < 640; c++) m_vd[c] = 16'(c * 97);
    line(100, 1000, 1000, 1000, 320, 400);
    lit("var_wall_c0", {31'd0, cap_wall[2]}, 1);
    lit("var_wall_c1", {31'd0, cap_wall[3]}, 1);
    lit("var_wall_c10", {31'd0, cap_wall[12]}, 0);
    lit("var_floor_c10", {31'd0, cap_floor[12]}, 0);
    lit("vchg_floor_c318", {31'd0, cap_floor[320]}, 0);
    lit("vchg_floor_c319", {31'd0, cap_floor[321]}, 0);
    lit("vchg_floor_c320", {31'd0, cap_floor[322]}, 1);
    lit("vchg_floor_c400", {31'd0, cap_floor[402]}, 1);

    plain(480);
    n_cs = 0; n_valid = 0;
    for (int i = 0; i < 800; i++) begin
      n_cs += int'(cap_cs[i]);
      if (i >= 2) n_valid += int'(cap_valid[i]);
    end
    lit("vblank480_cs", 32'(n_cs), 0);
    lit("vblank480_valid", 32'(n_valid), 0);
    plain(524);
    n_cs = 0; n_valid = 0;
    for (int i = 0; i < 800; i++) begin
      n_cs += int'(cap_cs[i]);
      n_valid += int'(cap_valid[i]);
    end
    lit("vblank524_cs", 32'(n_cs), 0);
    lit("vblank524_valid", 32'(n_valid), 0);

    plain(300);
    n_valid = 0;
    for (int i = 0; i < 800; i++) n_valid += int'(cap_valid[i]);
    lit("v300_valid_count", 32'(n_valid), 640);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
